// File: rtl/sorter.sv
// Buffers ELEMENT_NUM unsigned words, sorts them ascending with an odd-even
// transposition network (one phase per cycle), then writes them out in address order.
module sorter #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ELEMENT_NUM      = 16,
    parameter int unsigned LOG2_ELEMENT_NUM = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        UM_valid,
    input  logic [DATA_WIDTH-1:0]       UM_data,
    output logic                        SM_valid,
    output logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
    output logic [DATA_WIDTH-1:0]       SM_data,
    output logic                        done
);

    typedef enum logic [1:0] {StLoad, StSort, StWrite, StDone} state_e;

    localparam logic [LOG2_ELEMENT_NUM-1:0] LastIdx = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

    state_e                        r_state, w_state_next;
    logic [LOG2_ELEMENT_NUM-1:0]   r_cnt;
    logic [DATA_WIDTH-1:0]         r_mem [ELEMENT_NUM];
    logic [DATA_WIDTH-1:0]         w_phase [ELEMENT_NUM];
    logic                          w_last;
    logic                          r_sm_valid;
    logic [LOG2_ELEMENT_NUM-1:0]   r_sm_addr;
    logic [DATA_WIDTH-1:0]         r_sm_data;
    logic                          r_done;

    assign w_last = (r_cnt == LastIdx);

    // Even phases exchange pairs (0,1),(2,3)...; odd phases (1,2),(3,4)...
    always_comb begin
        w_phase = r_mem;
        for (int i = 0; i < int'(ELEMENT_NUM) - 1; i++) begin
            if ((i % 2) == int'(r_cnt[0]) && r_mem[i] > r_mem[i+1]) begin
                w_phase[i]   = r_mem[i+1];
                w_phase[i+1] = r_mem[i];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoad:  if (UM_valid && w_last) w_state_next = StSort;
            StSort:  if (w_last) w_state_next = StWrite;
            StWrite: if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StDone;
            default: w_state_next = StLoad;
        endcase
    end

    // One counter serves as load index, sort phase number and write address;
    // each stage ends at ELEMENT_NUM-1 so the natural wrap re-arms it at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StLoad;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == StLoad && UM_valid) || r_state == StSort || r_state == StWrite) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == StLoad && UM_valid) begin
                r_mem[r_cnt] <= UM_data;
            end else if (r_state == StSort) begin
                r_mem <= w_phase;
            end
        end
    end

    // Outputs lag the state by one cycle, so done follows the last write beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sm_valid <= 1'b0;
            r_sm_addr  <= '0;
            r_sm_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_sm_valid <= (r_state == StWrite);
            r_sm_addr  <= r_cnt;
            r_sm_data  <= r_mem[r_cnt];
            r_done     <= (r_state == StDone);
        end
    end

    assign SM_valid = r_sm_valid;
    assign SM_addr  = r_sm_addr;
    assign SM_data  = r_sm_data;
    assign done     = r_done;

endmodule

// File: tb/tb_sorter.sv
// Self-checking bench for sorter: directed vector table, randomized jobs with
// gaps against a queue-based reference sort, and a reset-during-write sequence.
module tb_sorter;

    localparam int DW    = 32;
    localparam int N     = 16;
    localparam int LG    = 4;
    localparam int BOUND = N * (DW + 2) + 16;

    typedef logic [N-1:0][DW-1:0] job_t;

    typedef struct {
        job_t vals;
        job_t exp;
        int   gap;
        int   extra;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          UM_valid = 1'b0;
    logic [DW-1:0] UM_data = '0;
    logic          SM_valid;
    logic [LG-1:0] SM_addr;
    logic [DW-1:0] SM_data;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] tb_mem [N];
    int            wcnt [N];
    int            beats = 0;
    logic          prev_done = 1'b0;

    sorter #(
        .DATA_WIDTH      (DW),
        .ELEMENT_NUM     (N),
        .LOG2_ELEMENT_NUM(LG)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .UM_valid(UM_valid),
        .UM_data (UM_data),
        .SM_valid(SM_valid),
        .SM_addr (SM_addr),
        .SM_data (SM_data),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Sorted-memory model: captures writes on the falling edge and polices the protocol.
    always @(negedge clk) begin
        if (SM_valid) begin
            checks++;
            if (wcnt[SM_addr] != 0) begin
                errors++;
                $display("FAIL addr_once addr=%0d prior_writes=%0d required=0", SM_addr, wcnt[SM_addr]);
            end
            checks++;
            if (done) begin
                errors++;
                $display("FAIL done_with_valid done=%0b required=0", done);
            end
            wcnt[SM_addr]++;
            tb_mem[SM_addr] = SM_data;
            beats++;
        end
        if (prev_done && !rst) begin
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL done_held done=%0b required=1", done);
            end
        end
        prev_done = done;
    end

    // Reference: repeatedly extract the minimum of the input multiset.
    function automatic job_t ref_sort(input job_t v);
        bit [DW-1:0] q[$];
        job_t        r;
        int          m;
        for (int i = 0; i < N; i++) q.push_back(v[i]);
        for (int k = 0; k < N; k++) begin
            m = 0;
            for (int j = 1; j < q.size(); j++) if (q[j] < q[m]) m = j;
            r[k] = q[m];
            q.delete(m);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Assert rst with a junk valid beat present, then verify the reset outputs.
    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1; UM_valid = 1'b1; UM_data = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; UM_valid = 1'b0;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        beats = 0;
        @(negedge clk);
        check("rst_sm_valid", DW'(SM_valid), '0);
        check("rst_done", DW'(done), '0);
        check("rst_sm_addr", DW'(SM_addr), '0);
        check("rst_sm_data", SM_data, '0);
        @(posedge clk); #1;
    endtask

    task automatic load(input job_t v, input int gap, input int extra);
        for (int i = 0; i < N; i++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                UM_valid = 1'b0; UM_data = $urandom;
                @(posedge clk); #1;
            end
            UM_valid = 1'b1; UM_data = v[i];
            @(posedge clk); #1;
        end
        for (int i = 0; i < extra; i++) begin
            UM_valid = 1'b1; UM_data = $urandom;
            @(posedge clk); #1;
        end
        UM_valid = 1'b0;
    endtask

    task automatic finish_check(input string name, input job_t exp, input int extra);
        int cyc = 0;
        while (!done && cyc < BOUND - extra) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_latency done=0 after %0d cycles required done=1", name, cyc);
        end
        check({name, "_beats"}, DW'(beats), DW'(N));
        for (int k = 0; k < N; k++) begin
            check({name, "_mem"}, tb_mem[k], exp[k]);
            check({name, "_wcnt"}, DW'(wcnt[k]), DW'(1));
        end
        repeat (3) @(negedge clk);
        check({name, "_done_hold"}, DW'(done), DW'(1));
        check({name, "_idle_valid"}, DW'(SM_valid), '0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t          vecs [5];
        logic [DW-1:0] msb_in  [N] = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7FFFFFFF,
                                       32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1,
                                       32'h7FFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF,
                                       32'h2, 32'h0, 32'h7FFFFFFF, 32'hFFFFFFFF};
        logic [DW-1:0] msb_exp [N] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h2,
                                       32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                       32'h80000000, 32'h80000000, 32'h80000000,
                                       32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                       32'hFFFFFFFF};
        job_t          a, b;
        int            cyc;

        for (int i = 0; i < N; i++) begin
            vecs[0].vals[i] = DW'(N - 1 - i);     vecs[0].exp[i] = DW'(i);
            vecs[1].vals[i] = msb_in[i];          vecs[1].exp[i] = msb_exp[i];
            vecs[2].vals[i] = DW'(i * 3 + 7);     vecs[2].exp[i] = DW'(i * 3 + 7);
            vecs[3].vals[i] = 32'hA5A5A5A5;       vecs[3].exp[i] = 32'hA5A5A5A5;
            vecs[4].vals[i] = DW'(N - 1 - i);     vecs[4].exp[i] = DW'(i);
        end
        vecs[0].gap = 0;  vecs[0].extra = 0;
        vecs[1].gap = 0;  vecs[1].extra = 0;
        vecs[2].gap = 0;  vecs[2].extra = 0;
        vecs[3].gap = 0;  vecs[3].extra = 0;
        vecs[4].gap = 40; vecs[4].extra = 3;

        for (int t = 0; t < 5; t++) begin
            reset_dut();
            load(vecs[t].vals, vecs[t].gap, vecs[t].extra);
            finish_check($sformatf("vec%0d", t), vecs[t].exp, vecs[t].extra);
        end

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) a[i] = (t % 2 == 0) ? $urandom : ($urandom & 32'h8000_0003);
            reset_dut();
            load(a, (t * 13) % 50, t % 3);
            finish_check($sformatf("rand%0d", t), ref_sort(a), t % 3);
        end

        // Abort a job partway through its write phase, then run a fresh one.
        for (int i = 0; i < N; i++) begin
            a[i] = $urandom;
            b[i] = $urandom & 32'hFF;
        end
        reset_dut();
        load(a, 0, 0);
        cyc = 0;
        while (beats < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("midwrite_reached", DW'(beats >= 5), DW'(1));
        reset_dut();
        load(b, 20, 0);
        check("midwrite_no_early_done", DW'(done), '0);
        finish_check("midwrite_newjob", ref_sort(b), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
